ipv4_pkt_router_mc: RTL and testbench
=====================================

Name: ipv4_pkt_router_mc

Overview:
Parametrised multi-channel IPv4 packet router for the gigabit MAC receive path, sitting between the IPv4 de-encapsulator and the protocol handlers (UDP, ICMP, ...).
- Pulls one IPv4 packet at a time as a byte stream and buffers the first 10 header bytes until the protocol byte is known.
- Checks the Total Length field against free space in the destination channel FIFO, then stores the packet whole or drops it whole.
- Each channel presents complete packets only, with per-channel ready/valid/last/read signals.
- Supports NUM_CH channels with a programmable protocol number each, plus runt and length-overrun detection.

Parameters:
- NUM_CH, 2, number of output channels.
- PROTO_LIST, {8'd1, 8'd17}, NUM_CH*8-bit packed list; slice [8c+7:8c] is the IPv4 protocol number for channel c (default: ch0=17 UDP, ch1=1 ICMP).
- FIFO_DEPTH, 2048, bytes per channel FIFO; power of 2, at least 64.
- MAX_PKTS, 16, maximum complete packets held per channel.

Ports:
- i_rxmac_clk, in, 1, receive MAC clock.
- i_rxmac_arst, in, 1, asynchronous active-high reset.
- i_ipv4_pkt_byte, in, 8, input packet byte.
- i_ipv4_pkt_byte_vld, in, 1, input byte valid.
- i_ipv4_pkt_last_byte, in, 1, input byte is the last byte of the packet.
- o_ipv4_pkt_byte_rd, out, 1, byte consumed this cycle when high together with vld.
- o_ch_pkt_byte_rdy, out, NUM_CH, channel holds at least one complete packet.
- o_ch_pkt_byte, out, NUM_CH*8, head byte per channel.
- o_ch_pkt_byte_vld, out, NUM_CH, head byte valid.
- o_ch_pkt_last_byte, out, NUM_CH, head byte is the last byte of its packet.
- i_ch_pkt_byte_rd, in, NUM_CH, pop head byte.
- o_ch_pkt_fifo_overflow, out, NUM_CH, one-cycle pulse: packet dropped for lack of space.
- o_unsupported_ipv4_protocol, out, 1, one-cycle pulse: no channel matches the protocol byte.
- o_malformed_pkt, out, 1, one-cycle pulse: runt packet or Total Length < 20.
- o_pkt_len_err, out, 1, one-cycle pulse: packet longer than Total Length; truncated.

Behaviour:
- Reset: all outputs 0, FIFOs and packet counts empty, FSM in HDR, header index 0. Reset mid-packet discards all partial state; upstream must be reset together with this block.
- Input handshake: a byte transfers on a clock edge where o_ipv4_pkt_byte_rd and i_ipv4_pkt_byte_vld are both 1. o_ipv4_pkt_byte_rd is 1 in HDR, STREAM and DROP, and 0 in DECIDE and FLUSH.
- HDR: capture bytes 0..9 into the header buffer. Total Length = {byte2, byte3}, 16 bits; protocol = byte9.
  - last on bytes 0..8: pulse o_malformed_pkt and return to HDR.
  - Byte 9 accepted: go to DECIDE.
- DECIDE (1 cycle): channel = lowest c whose PROTO_LIST slice equals the protocol byte.
  - No match: pulse o_unsupported_ipv4_protocol, go to DROP.
  - Total Length < 20: pulse o_malformed_pkt, go to DROP.
  - Total Length > free bytes (FIFO_DEPTH - occupancy), or pkt_count == MAX_PKTS: pulse o_ch_pkt_fifo_overflow[c], go to DROP.
  - Otherwise go to FLUSH.
  - If byte 9 itself carried last, the drop/pulse rules still apply, but the target state is HDR instead of DROP.
- FLUSH (10 cycles): write header bytes 0..9 to FIFO c, then go to STREAM. If byte 9 was last, byte 9 is written with the last bit set and the FSM returns to HDR.
- STREAM: write each accepted byte and count it (byte index 1-based).
  - Input last arrives at or before Total Length: byte written with last set, packet committed, go to HDR.
  - Byte index reaches Total Length without input last: byte written with last set, packet committed, pulse o_pkt_len_err, go to DROP.
  - A short packet (input last before Total Length) is legal and is committed.
- DROP: accept and discard bytes until input last, then go to HDR.
- Channel FIFO:
  - Stores 9 bits per entry (byte plus last flag); first-word fall-through.
  - Space is checked against Total Length, so a committed packet can never overflow the FIFO.
  - pkt_count increments on commit and decrements when a last byte is popped. Simultaneous commit and pop leave the count unchanged.
  - o_ch_pkt_byte_rdy[c] = (pkt_count[c] != 0); asserts the cycle after commit.
  - o_ch_pkt_byte_vld[c] = o_ch_pkt_byte_rdy[c] and FIFO not empty.
  - i_ch_pkt_byte_rd[c] while vld is 0 is ignored.
  - Write and read in the same cycle are allowed. Occupancy counters use log2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
- Latency: header byte 9 accepted -> 11 cycles until the next input accept. Last byte accepted -> rdy high 1 cycle later.

Test Plan:
1. UDP packet, proto 17, Total Length 28, 28 bytes -> o_ch_pkt_byte_rdy[0]=1; reading 28 bytes returns the input sequence unchanged; last set only on byte 28; rdy[1] stays 0.
2. ICMP packet, proto 1, length 60, followed back-to-back by UDP length 40 -> each lands on its own channel intact; rd stalls exactly 11 cycles per packet header.
3. Proto 6 packet, length 40 -> o_unsupported_ipv4_protocol pulses once; all 40 bytes consumed; no rdy asserted; the following UDP packet routes correctly.
4. FIFO_DEPTH=64, no reads: UDP length 60, then UDP length 20 -> second packet dropped, o_ch_pkt_fifo_overflow[0] pulses once; first packet reads back intact; after draining, a length-20 packet is accepted.
5. Runt: last on byte 5 -> o_malformed_pkt pulses, nothing written. Separately, Total Length 10 with last at byte 10 -> o_malformed_pkt pulses (DECIDE), nothing written.
6. Total Length 30 but 35 bytes supplied -> 30 bytes stored with last on byte 30; o_pkt_len_err pulses; bytes 31..35 discarded; assert i_rxmac_arst mid-packet -> all outputs 0, rdy cleared.

Source files
------------

// File: rtl/ipv4_pkt_router_mc_if.sv
// Byte-stream bus between the IPv4 de-encapsulator, the router and the per-channel
// protocol handlers. The router takes the slave side.
interface ipv4_pkt_router_mc_if #(
    parameter int NUM_CH = 2
);
    logic [7:0]          i_ipv4_pkt_byte;
    logic                i_ipv4_pkt_byte_vld;
    logic                i_ipv4_pkt_last_byte;
    logic                o_ipv4_pkt_byte_rd;
    logic [NUM_CH-1:0]   o_ch_pkt_byte_rdy;
    logic [NUM_CH*8-1:0] o_ch_pkt_byte;
    logic [NUM_CH-1:0]   o_ch_pkt_byte_vld;
    logic [NUM_CH-1:0]   o_ch_pkt_last_byte;
    logic [NUM_CH-1:0]   i_ch_pkt_byte_rd;
    logic [NUM_CH-1:0]   o_ch_pkt_fifo_overflow;
    logic                o_unsupported_ipv4_protocol;
    logic                o_malformed_pkt;
    logic                o_pkt_len_err;

    modport slave (
        input  i_ipv4_pkt_byte, i_ipv4_pkt_byte_vld, i_ipv4_pkt_last_byte, i_ch_pkt_byte_rd,
        output o_ipv4_pkt_byte_rd, o_ch_pkt_byte_rdy, o_ch_pkt_byte, o_ch_pkt_byte_vld,
               o_ch_pkt_last_byte, o_ch_pkt_fifo_overflow, o_unsupported_ipv4_protocol,
               o_malformed_pkt, o_pkt_len_err
    );

    modport master (
        output i_ipv4_pkt_byte, i_ipv4_pkt_byte_vld, i_ipv4_pkt_last_byte, i_ch_pkt_byte_rd,
        input  o_ipv4_pkt_byte_rd, o_ch_pkt_byte_rdy, o_ch_pkt_byte, o_ch_pkt_byte_vld,
               o_ch_pkt_last_byte, o_ch_pkt_fifo_overflow, o_unsupported_ipv4_protocol,
               o_malformed_pkt, o_pkt_len_err
    );
endinterface

// File: rtl/ipv4_pkt_router_mc.sv
// Multi-channel IPv4 packet router: buffers the first 10 header bytes, picks a channel
// by protocol number and stores each packet whole into that channel's FIFO or drops it whole.
module ipv4_pkt_router_mc #(
    parameter int                  NUM_CH     = 2,
    parameter logic [NUM_CH*8-1:0] PROTO_LIST = {8'd1, 8'd17},
    parameter int                  FIFO_DEPTH = 2048,
    parameter int                  MAX_PKTS   = 16
) (
    input logic                 i_rxmac_clk,
    input logic                 i_rxmac_arst,
    ipv4_pkt_router_mc_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = $clog2(MAX_PKTS + 1);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {HDR, DECIDE, FLUSH, STREAM, DROP} state_t;

    state_t      state, state_nxt;
    logic [7:0]  hdr_buf [10];
    logic [3:0]  hdr_idx, hdr_idx_nxt;
    logic [3:0]  flush_idx, flush_idx_nxt;
    logic [15:0] byte_cnt, byte_cnt_nxt;
    logic [CW-1:0] ch_reg, ch_nxt;
    logic        b9_last, b9_last_nxt;
    logic        rd_q, rd_nxt;
    logic        accept;
    logic [15:0] total_len;
    logic        match;
    logic [CW-1:0] match_ch;
    logic        no_space;
    logic        at_len;

    logic [NUM_CH-1:0] wr_en, commit;
    logic [8:0]        wr_data;
    logic [NUM_CH*(AW+1)-1:0] occ_all;
    logic [NUM_CH*PW-1:0]     pcnt_all;
    logic [AW:0]       occ_sel;
    logic [PW-1:0]     pcnt_sel;

    logic              malformed_q, malformed_nxt;
    logic              unsup_q, unsup_nxt;
    logic              len_err_q, len_err_nxt;
    logic [NUM_CH-1:0] ovf_q, ovf_nxt;

    logic [NUM_CH-1:0]   rdy_v, vld_v, last_v;
    logic [NUM_CH*8-1:0] byte_v;

    assign accept    = rd_q && bus.i_ipv4_pkt_byte_vld;
    assign total_len = {hdr_buf[2], hdr_buf[3]};
    assign at_len    = ((byte_cnt + 16'd1) == total_len);

    // Lowest-numbered channel wins when several share a protocol number.
    always_comb begin
        match    = 1'b0;
        match_ch = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (PROTO_LIST[8*c +: 8] == hdr_buf[9]) begin
                match    = 1'b1;
                match_ch = CW'(c);
            end
        end
    end

    assign occ_sel  = occ_all[match_ch*(AW+1) +: (AW+1)];
    assign pcnt_sel = pcnt_all[match_ch*PW +: PW];
    assign no_space = (32'(total_len) > (32'(FIFO_DEPTH) - 32'(occ_sel))) ||
                      (32'(pcnt_sel) == 32'(MAX_PKTS));

    always_comb begin
        state_nxt     = state;
        hdr_idx_nxt   = hdr_idx;
        flush_idx_nxt = flush_idx;
        byte_cnt_nxt  = byte_cnt;
        ch_nxt        = ch_reg;
        b9_last_nxt   = b9_last;
        wr_en         = '0;
        commit        = '0;
        wr_data       = '0;
        malformed_nxt = 1'b0;
        unsup_nxt     = 1'b0;
        len_err_nxt   = 1'b0;
        ovf_nxt       = '0;
        case (state)
            HDR: begin
                if (accept) begin
                    if (hdr_idx == 4'd9) begin
                        hdr_idx_nxt = '0;
                        b9_last_nxt = bus.i_ipv4_pkt_last_byte;
                        state_nxt   = DECIDE;
                    end else if (bus.i_ipv4_pkt_last_byte) begin
                        hdr_idx_nxt   = '0;
                        malformed_nxt = 1'b1;
                    end else begin
                        hdr_idx_nxt = hdr_idx + 4'd1;
                    end
                end
            end
            DECIDE: begin
                ch_nxt        = match_ch;
                flush_idx_nxt = '0;
                byte_cnt_nxt  = 16'd10;
                if (!match) begin
                    unsup_nxt = 1'b1;
                    state_nxt = b9_last ? HDR : DROP;
                end else if (total_len < 16'd20) begin
                    malformed_nxt = 1'b1;
                    state_nxt     = b9_last ? HDR : DROP;
                end else if (no_space) begin
                    ovf_nxt[match_ch] = 1'b1;
                    state_nxt         = b9_last ? HDR : DROP;
                end else begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                wr_en[ch_reg] = 1'b1;
                wr_data       = {(flush_idx == 4'd9) && b9_last, hdr_buf[flush_idx]};
                if (flush_idx == 4'd9) begin
                    if (b9_last) begin
                        commit[ch_reg] = 1'b1;
                        state_nxt      = HDR;
                    end else begin
                        state_nxt = STREAM;
                    end
                end else begin
                    flush_idx_nxt = flush_idx + 4'd1;
                end
            end
            STREAM: begin
                if (accept) begin
                    byte_cnt_nxt  = byte_cnt + 16'd1;
                    wr_en[ch_reg] = 1'b1;
                    wr_data       = {bus.i_ipv4_pkt_last_byte || at_len, bus.i_ipv4_pkt_byte};
                    if (bus.i_ipv4_pkt_last_byte || at_len) commit[ch_reg] = 1'b1;
                    if (bus.i_ipv4_pkt_last_byte) begin
                        state_nxt = HDR;
                    end else if (at_len) begin
                        len_err_nxt = 1'b1;
                        state_nxt   = DROP;
                    end
                end
            end
            DROP: begin
                if (accept && bus.i_ipv4_pkt_last_byte) state_nxt = HDR;
            end
            default: state_nxt = HDR;
        endcase
        rd_nxt = (state_nxt == HDR) || (state_nxt == STREAM) || (state_nxt == DROP);
    end

    always_ff @(posedge i_rxmac_clk or posedge i_rxmac_arst) begin
        if (i_rxmac_arst) begin
            state       <= HDR;
            hdr_idx     <= '0;
            flush_idx   <= '0;
            byte_cnt    <= '0;
            ch_reg      <= '0;
            b9_last     <= 1'b0;
            rd_q        <= 1'b0;
            malformed_q <= 1'b0;
            unsup_q     <= 1'b0;
            len_err_q   <= 1'b0;
            ovf_q       <= '0;
        end else begin
            state       <= state_nxt;
            hdr_idx     <= hdr_idx_nxt;
            flush_idx   <= flush_idx_nxt;
            byte_cnt    <= byte_cnt_nxt;
            ch_reg      <= ch_nxt;
            b9_last     <= b9_last_nxt;
            rd_q        <= rd_nxt;
            malformed_q <= malformed_nxt;
            unsup_q     <= unsup_nxt;
            len_err_q   <= len_err_nxt;
            ovf_q       <= ovf_nxt;
        end
    end

    always_ff @(posedge i_rxmac_clk) begin
        if (state == HDR && accept) hdr_buf[hdr_idx] <= bus.i_ipv4_pkt_byte;
    end

    // Per-channel first-word fall-through FIFO with a complete-packet counter.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [8:0]    mem [FIFO_DEPTH];
        logic [AW-1:0] wp, rp;
        logic [AW:0]   occ;
        logic [PW-1:0] pcnt;
        logic [8:0]    head;
        logic          vld, pop, pop_last;

        assign head     = mem[rp];
        assign vld      = (pcnt != '0) && (occ != '0);
        assign pop      = bus.i_ch_pkt_byte_rd[c] && vld;
        assign pop_last = pop && head[8];

        always_ff @(posedge i_rxmac_clk) begin
            if (wr_en[c]) mem[wp] <= wr_data;
        end

        always_ff @(posedge i_rxmac_clk or posedge i_rxmac_arst) begin
            if (i_rxmac_arst) begin
                wp   <= '0;
                rp   <= '0;
                occ  <= '0;
                pcnt <= '0;
            end else begin
                if (wr_en[c]) wp <= wp + 1'b1;
                if (pop)      rp <= rp + 1'b1;
                case ({wr_en[c], pop})
                    2'b10:   occ <= occ + 1'b1;
                    2'b01:   occ <= occ - 1'b1;
                    default: occ <= occ;
                endcase
                if (commit[c] && !pop_last)      pcnt <= pcnt + 1'b1;
                else if (!commit[c] && pop_last) pcnt <= pcnt - 1'b1;
            end
        end

        assign occ_all[c*(AW+1) +: (AW+1)] = occ;
        assign pcnt_all[c*PW +: PW]        = pcnt;
        assign rdy_v[c]                    = (pcnt != '0);
        assign vld_v[c]                    = vld;
        assign last_v[c]                   = vld && head[8];
        assign byte_v[8*c +: 8]            = vld ? head[7:0] : 8'd0;
    end

    assign bus.o_ipv4_pkt_byte_rd          = rd_q;
    assign bus.o_ch_pkt_byte_rdy           = rdy_v;
    assign bus.o_ch_pkt_byte_vld           = vld_v;
    assign bus.o_ch_pkt_last_byte          = last_v;
    assign bus.o_ch_pkt_byte               = byte_v;
    assign bus.o_ch_pkt_fifo_overflow      = ovf_q;
    assign bus.o_unsupported_ipv4_protocol = unsup_q;
    assign bus.o_malformed_pkt             = malformed_q;
    assign bus.o_pkt_len_err               = len_err_q;
endmodule

// File: tb/tb_ipv4_pkt_router_mc.sv
// Directed bench for ipv4_pkt_router_mc with 64-byte channel FIFOs; each task covers one
// scenario and compares observed values against hand-derived expectations.
module tb_ipv4_pkt_router_mc;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   n_mal, n_unsup, n_len, n_ovf0, n_ovf1;

    ipv4_pkt_router_mc_if #(.NUM_CH(2)) bus ();

    ipv4_pkt_router_mc #(
        .NUM_CH(2),
        .PROTO_LIST({8'd1, 8'd17}),
        .FIFO_DEPTH(64),
        .MAX_PKTS(16)
    ) dut (
        .i_rxmac_clk (clk),
        .i_rxmac_arst(rst),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.o_malformed_pkt)             n_mal++;
        if (bus.o_unsupported_ipv4_protocol) n_unsup++;
        if (bus.o_pkt_len_err)               n_len++;
        if (bus.o_ch_pkt_fifo_overflow[0])   n_ovf0++;
        if (bus.o_ch_pkt_fifo_overflow[1])   n_ovf1++;
    end

    // Packet content is a pure function of (proto, length, seed, index).
    function automatic logic [7:0] pkt_byte(input logic [7:0] proto, input logic [15:0] len,
                                            input logic [7:0] seed, input int i);
        case (i)
            0:       return 8'h45;
            1:       return 8'h00;
            2:       return len[15:8];
            3:       return len[7:0];
            9:       return proto;
            default: return seed + 8'(i * 3);
        endcase
    endfunction

    task automatic send_pkt(input logic [7:0] proto, input logic [15:0] len, input logic [7:0] seed,
                            input int n, input bit give_last, output int accepted, output int max_stall);
        int run;
        int guard;
        accepted  = 0;
        max_stall = 0;
        run       = 0;
        guard     = 0;
        while (accepted < n && guard < 2000) begin
            bus.i_ipv4_pkt_byte      = pkt_byte(proto, len, seed, accepted);
            bus.i_ipv4_pkt_byte_vld  = 1'b1;
            bus.i_ipv4_pkt_last_byte = give_last && (accepted == n - 1);
            if (bus.o_ipv4_pkt_byte_rd) begin
                accepted++;
                run = 0;
            end else begin
                run++;
                if (run > max_stall) max_stall = run;
            end
            @(negedge clk);
            guard++;
        end
        bus.i_ipv4_pkt_byte_vld  = 1'b0;
        bus.i_ipv4_pkt_last_byte = 1'b0;
    endtask

    task automatic read_pkt(input int c, input logic [7:0] proto, input logic [15:0] len,
                            input logic [7:0] seed, input int n, output int got, output int errs);
        int guard;
        logic [8:0] exp_v;
        logic [8:0] act_v;
        got   = 0;
        errs  = 0;
        guard = 0;
        while (got < n && guard < 1000) begin
            @(negedge clk);
            bus.i_ch_pkt_byte_rd[c] = 1'b0;
            if (bus.o_ch_pkt_byte_vld[c]) begin
                exp_v = {(got == n - 1), pkt_byte(proto, len, seed, got)};
                act_v = {bus.o_ch_pkt_last_byte[c], bus.o_ch_pkt_byte[8*c +: 8]};
                if (act_v !== exp_v) begin
                    if (errs == 0)
                        $display("[TB] ch%0d byte %0d: got %h want %h", c, got, act_v, exp_v);
                    errs++;
                end
                got++;
                bus.i_ch_pkt_byte_rd[c] = 1'b1;
            end
            guard++;
        end
        @(negedge clk);
        bus.i_ch_pkt_byte_rd[c] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (bus.o_ipv4_pkt_byte_rd !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_rd: got %b want 0", bus.o_ipv4_pkt_byte_rd);
        end
        total++;
        if ({bus.o_ch_pkt_byte_rdy, bus.o_ch_pkt_byte_vld, bus.o_ch_pkt_last_byte} !== 6'b0) begin
            bad++; $display("[TB] FAIL reset_ch: got %b want 0",
                            {bus.o_ch_pkt_byte_rdy, bus.o_ch_pkt_byte_vld, bus.o_ch_pkt_last_byte});
        end
        total++;
        if ({bus.o_ch_pkt_fifo_overflow, bus.o_unsupported_ipv4_protocol, bus.o_malformed_pkt,
             bus.o_pkt_len_err} !== 5'b0) begin
            bad++; $display("[TB] FAIL reset_pulses: not all zero");
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.o_ipv4_pkt_byte_rd !== 1'b1) begin
            bad++; $display("[TB] FAIL post_reset_rd: got %b want 1", bus.o_ipv4_pkt_byte_rd);
        end
    endtask

    task automatic test_udp;
        int acc, st, got, errs;
        send_pkt(8'd17, 16'd28, 8'h10, 28, 1'b1, acc, st);
        total++;
        if (acc !== 28 || st !== 11) begin
            bad++; $display("[TB] FAIL udp_send: accepted=%0d stall=%0d want 28/11", acc, st);
        end
        total++;
        if (bus.o_ch_pkt_byte_rdy !== 2'b01) begin
            bad++; $display("[TB] FAIL udp_rdy: got %b want 01", bus.o_ch_pkt_byte_rdy);
        end
        read_pkt(0, 8'd17, 16'd28, 8'h10, 28, got, errs);
        total++;
        if (got !== 28 || errs !== 0) begin
            bad++; $display("[TB] FAIL udp_data: got=%0d errs=%0d want 28/0", got, errs);
        end
        total++;
        if (bus.o_ch_pkt_byte_rdy !== 2'b00) begin
            bad++; $display("[TB] FAIL udp_drained: got %b want 00", bus.o_ch_pkt_byte_rdy);
        end
    endtask

    task automatic test_back_to_back;
        int acc1, st1, acc2, st2, got, errs;
        send_pkt(8'd1, 16'd60, 8'h20, 60, 1'b1, acc1, st1);
        send_pkt(8'd17, 16'd40, 8'h30, 40, 1'b1, acc2, st2);
        total++;
        if (acc1 !== 60 || acc2 !== 40 || st1 !== 11 || st2 !== 11) begin
            bad++; $display("[TB] FAIL b2b_send: acc=%0d/%0d stall=%0d/%0d want 60/40 11/11",
                            acc1, acc2, st1, st2);
        end
        total++;
        if (bus.o_ch_pkt_byte_rdy !== 2'b11) begin
            bad++; $display("[TB] FAIL b2b_rdy: got %b want 11", bus.o_ch_pkt_byte_rdy);
        end
        read_pkt(1, 8'd1, 16'd60, 8'h20, 60, got, errs);
        total++;
        if (got !== 60 || errs !== 0) begin
            bad++; $display("[TB] FAIL b2b_icmp_data: got=%0d errs=%0d want 60/0", got, errs);
        end
        read_pkt(0, 8'd17, 16'd40, 8'h30, 40, got, errs);
        total++;
        if (got !== 40 || errs !== 0) begin
            bad++; $display("[TB] FAIL b2b_udp_data: got=%0d errs=%0d want 40/0", got, errs);
        end
    endtask

    task automatic test_unsupported;
        int acc, st, got, errs, m0;
        m0 = n_unsup;
        send_pkt(8'd6, 16'd40, 8'h40, 40, 1'b1, acc, st);
        repeat (3) @(negedge clk);
        total++;
        if (acc !== 40 || (n_unsup - m0) !== 1) begin
            bad++; $display("[TB] FAIL unsup: accepted=%0d pulses=%0d want 40/1", acc, n_unsup - m0);
        end
        total++;
        if (bus.o_ch_pkt_byte_rdy !== 2'b00) begin
            bad++; $display("[TB] FAIL unsup_rdy: got %b want 00", bus.o_ch_pkt_byte_rdy);
        end
        send_pkt(8'd17, 16'd20, 8'h50, 20, 1'b1, acc, st);
        read_pkt(0, 8'd17, 16'd20, 8'h50, 20, got, errs);
        total++;
        if (got !== 20 || errs !== 0) begin
            bad++; $display("[TB] FAIL unsup_next: got=%0d errs=%0d want 20/0", got, errs);
        end
    endtask

    task automatic test_overflow;
        int acc, st, got, errs, o0, o1;
        o0 = n_ovf0;
        o1 = n_ovf1;
        send_pkt(8'd17, 16'd60, 8'h60, 60, 1'b1, acc, st);
        send_pkt(8'd17, 16'd20, 8'h70, 20, 1'b1, acc, st);
        repeat (3) @(negedge clk);
        total++;
        if ((n_ovf0 - o0) !== 1 || (n_ovf1 - o1) !== 0) begin
            bad++; $display("[TB] FAIL ovf_pulse: ch0=%0d ch1=%0d want 1/0", n_ovf0 - o0, n_ovf1 - o1);
        end
        read_pkt(0, 8'd17, 16'd60, 8'h60, 60, got, errs);
        total++;
        if (got !== 60 || errs !== 0) begin
            bad++; $display("[TB] FAIL ovf_first: got=%0d errs=%0d want 60/0", got, errs);
        end
        total++;
        if (bus.o_ch_pkt_byte_rdy !== 2'b00) begin
            bad++; $display("[TB] FAIL ovf_dropped: rdy got %b want 00", bus.o_ch_pkt_byte_rdy);
        end
        send_pkt(8'd17, 16'd20, 8'h80, 20, 1'b1, acc, st);
        read_pkt(0, 8'd17, 16'd20, 8'h80, 20, got, errs);
        total++;
        if (got !== 20 || errs !== 0) begin
            bad++; $display("[TB] FAIL ovf_after_drain: got=%0d errs=%0d want 20/0", got, errs);
        end
    endtask

    task automatic test_malformed;
        int acc, st, m0;
        m0 = n_mal;
        send_pkt(8'd17, 16'd40, 8'h90, 6, 1'b1, acc, st);
        repeat (3) @(negedge clk);
        total++;
        if ((n_mal - m0) !== 1 || bus.o_ch_pkt_byte_rdy !== 2'b00) begin
            bad++; $display("[TB] FAIL runt: pulses=%0d rdy=%b want 1/00", n_mal - m0, bus.o_ch_pkt_byte_rdy);
        end
        m0 = n_mal;
        send_pkt(8'd17, 16'd10, 8'hA0, 10, 1'b1, acc, st);
        repeat (3) @(negedge clk);
        total++;
        if (acc !== 10 || (n_mal - m0) !== 1 || bus.o_ch_pkt_byte_rdy !== 2'b00) begin
            bad++; $display("[TB] FAIL short_len: acc=%0d pulses=%0d rdy=%b want 10/1/00",
                            acc, n_mal - m0, bus.o_ch_pkt_byte_rdy);
        end
    endtask

    task automatic test_len_err;
        int acc, st, got, errs, m0;
        m0 = n_len;
        send_pkt(8'd17, 16'd30, 8'hB0, 35, 1'b1, acc, st);
        repeat (2) @(negedge clk);
        total++;
        if (acc !== 35 || (n_len - m0) !== 1) begin
            bad++; $display("[TB] FAIL len_err: acc=%0d pulses=%0d want 35/1", acc, n_len - m0);
        end
        read_pkt(0, 8'd17, 16'd30, 8'hB0, 30, got, errs);
        total++;
        if (got !== 30 || errs !== 0 || bus.o_ch_pkt_byte_rdy !== 2'b00) begin
            bad++; $display("[TB] FAIL len_err_data: got=%0d errs=%0d rdy=%b want 30/0/00",
                            got, errs, bus.o_ch_pkt_byte_rdy);
        end
    endtask

    task automatic test_reset_mid_packet;
        int acc, st, got, errs;
        send_pkt(8'd17, 16'd20, 8'hC0, 20, 1'b1, acc, st);
        send_pkt(8'd17, 16'd40, 8'hD0, 15, 1'b0, acc, st);
        rst = 1'b1;
        #1;
        total++;
        if ({bus.o_ipv4_pkt_byte_rd, bus.o_ch_pkt_byte_rdy, bus.o_ch_pkt_byte_vld,
             bus.o_ch_pkt_last_byte, bus.o_ch_pkt_byte} !== 23'b0) begin
            bad++; $display("[TB] FAIL mid_reset_outputs: rd=%b rdy=%b vld=%b byte=%h want all 0",
                            bus.o_ipv4_pkt_byte_rd, bus.o_ch_pkt_byte_rdy, bus.o_ch_pkt_byte_vld,
                            bus.o_ch_pkt_byte);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.o_ch_pkt_byte_rdy !== 2'b00 || bus.o_ipv4_pkt_byte_rd !== 1'b1) begin
            bad++; $display("[TB] FAIL mid_reset_after: rdy=%b rd=%b want 00/1",
                            bus.o_ch_pkt_byte_rdy, bus.o_ipv4_pkt_byte_rd);
        end
        send_pkt(8'd17, 16'd20, 8'hE0, 20, 1'b1, acc, st);
        read_pkt(0, 8'd17, 16'd20, 8'hE0, 20, got, errs);
        total++;
        if (got !== 20 || errs !== 0) begin
            bad++; $display("[TB] FAIL mid_reset_next: got=%0d errs=%0d want 20/0", got, errs);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.i_ipv4_pkt_byte      = 8'd0;
        bus.i_ipv4_pkt_byte_vld  = 1'b0;
        bus.i_ipv4_pkt_last_byte = 1'b0;
        bus.i_ch_pkt_byte_rd     = 2'b00;
        @(negedge clk);
        test_reset;
        test_udp;
        test_back_to_back;
        test_unsupported;
        test_overflow;
        test_malformed;
        test_len_err;
        test_reset_mid_packet;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
